// File: rtl/ram_burst_ctrl.sv
// ============================================================================
// ram_burst_ctrl : valid/ready burst sequencer for a single-port RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_burst_ctrl #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 10,
  parameter int LEN_SIZE  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic                 i_cmd_wr,
  input  logic [ADDR_SIZE-1:0] i_cmd_addr,
  input  logic [LEN_SIZE-1:0]  i_cmd_len,
  input  logic [WORD_SIZE-1:0] i_wdata,
  input  logic                 i_wdata_valid,
  output logic                 o_wdata_ready,
  output logic [WORD_SIZE-1:0] o_rdata,
  output logic                 o_rdata_valid,
  input  logic                 i_rdata_ready,
  output logic                 o_busy,
  output logic [ADDR_SIZE-1:0] o_ram_addr,
  output logic [WORD_SIZE-1:0] o_ram_data_in,
  output logic                 o_ram_wr,
  output logic                 o_ram_cs,
  input  logic [WORD_SIZE-1:0] i_ram_data_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_t;

  localparam logic [ADDR_SIZE-1:0] c_addr_one = ADDR_SIZE'(1);
  localparam logic [LEN_SIZE-1:0]  c_cnt_one  = LEN_SIZE'(1);
  localparam logic [LEN_SIZE-1:0]  c_cnt_zero = '0;

  state_t               r_state;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [LEN_SIZE-1:0]  r_cnt;
  logic [WORD_SIZE-1:0] r_rdata;
  logic                 r_rdata_valid;

  logic w_wr_beat;
  logic w_capture;

  assign w_wr_beat = (r_state == S_WRITE) && i_wdata_valid;
  assign w_capture = (r_state == S_READ) && (!r_rdata_valid || i_rdata_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_cnt         <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      // The output slot drains independently of the FSM outside READ,
      // so a new command can be taken while a beat is still pending.
      if (r_state != S_READ && i_rdata_ready) begin
        r_rdata_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_addr  <= i_cmd_addr;
            r_cnt   <= i_cmd_len;
            r_state <= i_cmd_wr ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (w_wr_beat) begin
            r_addr <= r_addr + c_addr_one;
            if (r_cnt == c_cnt_zero) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - c_cnt_one;
            end
          end
        end
        S_READ: begin
          if (w_capture) begin
            r_rdata       <= i_ram_data_out;
            r_rdata_valid <= 1'b1;
            r_addr        <= r_addr + c_addr_one;
            if (r_cnt == c_cnt_zero) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - c_cnt_one;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_ready   = (r_state == S_IDLE) && !rst;
  assign o_busy        = (r_state != S_IDLE);
  assign o_wdata_ready = (r_state == S_WRITE);
  assign o_ram_wr      = w_wr_beat;
  assign o_ram_cs      = w_wr_beat || (r_state == S_READ);
  assign o_ram_addr    = r_addr;
  assign o_ram_data_in = i_wdata;
  assign o_rdata       = r_rdata;
  assign o_rdata_valid = r_rdata_valid;

endmodule

`default_nettype wire

// File: tb/tb_ram_burst_ctrl.sv
// ============================================================================
// tb_ram_burst_ctrl : directed + randomized bench with RAM and memory model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ram_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_wr;
  logic [9:0] cmd_addr;
  logic [3:0] cmd_len;
  logic [7:0] wdata;
  logic       wdata_valid, wdata_ready;
  logic [7:0] rdata;
  logic       rdata_valid, rdata_ready, busy;
  logic [9:0] ram_addr;
  logic [7:0] ram_data_in, ram_data_out;
  logic       ram_wr, ram_cs;
  logic       mem_clr;

  logic [7:0] mem     [1024];
  logic [7:0] ref_mem [1024];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_burst_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_wr       (cmd_wr),
    .i_cmd_addr     (cmd_addr),
    .i_cmd_len      (cmd_len),
    .i_wdata        (wdata),
    .i_wdata_valid  (wdata_valid),
    .o_wdata_ready  (wdata_ready),
    .o_rdata        (rdata),
    .o_rdata_valid  (rdata_valid),
    .i_rdata_ready  (rdata_ready),
    .o_busy         (busy),
    .o_ram_addr     (ram_addr),
    .o_ram_data_in  (ram_data_in),
    .o_ram_wr       (ram_wr),
    .o_ram_cs       (ram_cs),
    .i_ram_data_out (ram_data_out)
  );

  // Single-port RAM: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (ram_cs && ram_wr) begin
      mem[ram_addr] <= ram_data_in;
    end
  end
  assign ram_data_out = mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_wdata_ready"}, wdata_ready, 0);
    check({tag, "_ram_wr"}, ram_wr, 0);
    check({tag, "_ram_cs"}, ram_cs, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_rdata_valid"}, rdata_valid, 0);
  endtask

  // base < 0 selects random beat data, otherwise beat i carries base+i.
  task automatic write_burst(input logic [9:0] a, input int len, input int base,
                             input int stall_at, input int stall_n);
    int beat, gap;
    logic [7:0] d;
    logic [9:0] ea;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = a; cmd_len = len[3:0];
    #1 check("wr_accept_rdy", cmd_ready, 1);
    beat = 0; gap = 0;
    while (beat <= len) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      ea = a + beat[9:0];
      if (beat == stall_at && gap < stall_n) begin
        wdata_valid = 1'b0;
        gap++;
        #1;
        check("wr_stall_wr", ram_wr, 0);
        check("wr_stall_addr", ram_addr, ea);
        check("wr_stall_busy", busy, 1);
      end else begin
        d = (base < 0) ? 8'($urandom) : 8'(base + beat);
        wdata = d; wdata_valid = 1'b1;
        #1;
        check("wr_beat_wr", ram_wr, 1);
        check("wr_beat_cs", ram_cs, 1);
        check("wr_beat_addr", ram_addr, ea);
        check("wr_beat_data", ram_data_in, d);
        check("wr_beat_busy", busy, 1);
        ref_mem[ea] = d;
        beat++;
      end
    end
    @(negedge clk);
    wdata_valid = 1'b0;
    #1;
    check("wr_done_busy", busy, 0);
    check("wr_done_rdy", cmd_ready, 1);
    check("wr_done_wr", ram_wr, 0);
  endtask

  task automatic read_burst(input logic [9:0] a, input int len, input int bp_at, input int bp_n);
    logic [7:0] got[$];
    int cyc, stalls;
    logic [7:0] hd;
    logic [9:0] ha, ea;
    hd = '0; ha = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = a; cmd_len = len[3:0]; rdata_ready = 1'b1;
    #1 check("rd_accept_rdy", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check("rd_first_valid", rdata_valid, 0);
    check("rd_busy", busy, 1);
    check("rd_cs", ram_cs, 1);
    check("rd_wr", ram_wr, 0);
    check("rd_addr0", ram_addr, a);
    cyc = 0;
    stalls = (bp_at >= 0) ? bp_n : 0;
    while (got.size() <= 32'(len) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      rdata_ready = !(bp_at >= 0 && cyc >= bp_at && cyc < bp_at + bp_n);
      #1;
      if (!rdata_ready) begin
        if (cyc == bp_at) begin
          hd = rdata; ha = ram_addr;
        end else begin
          check("rd_bp_data", rdata, hd);
          check("rd_bp_addr", ram_addr, ha);
        end
      end else if (rdata_valid) begin
        got.push_back(rdata);
      end
    end
    rdata_ready = 1'b1;
    check("rd_cycles", cyc, len + 1 + stalls);
    check("rd_done_busy", busy, 0);
    check("rd_beats", got.size(), len + 1);
    for (int i = 0; i < got.size() && i <= len; i++) begin
      ea = a + 10'(i);
      check("rd_data", got[i], ref_mem[ea]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [9:0] a;
    int len;
    rst = 1'b1; mem_clr = 1'b1;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata = '0; wdata_valid = 1'b0; rdata_ready = 1'b1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

    @(negedge clk);
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    mem_clr = 1'b0; rst = 1'b0;
    #1;
    check("post_rst_rdy", cmd_ready, 1);
    check("post_rst_busy", busy, 0);

    // Basic write then read-back
    write_burst(10'h010, 3, 8'hA0, -1, 0);
    read_burst(10'h010, 3, -1, 0);

    // Address wrap across 0x3FF
    write_burst(10'h3FE, 3, -1, -1, 0);
    read_burst(10'h3FE, 3, -1, 0);

    // Write stall of two cycles mid-burst
    write_burst(10'h155, 5, -1, 2, 2);
    read_burst(10'h155, 5, -1, 0);

    // Read backpressure of three cycles
    write_burst(10'h080, 3, -1, -1, 0);
    read_burst(10'h080, 3, 2, 3);

    // Reset during beat 2 of a 4-beat write
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 10'h100; cmd_len = 4'd3;
    #1 check("rst_accept_rdy", cmd_ready, 1);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      d = 8'($urandom_range(1, 255));
      wdata = d; wdata_valid = 1'b1;
      ref_mem[10'h100 + 10'(b)] = d;
      #1 check("rst_pre_wr", ram_wr, 1);
    end
    @(negedge clk);
    wdata = 8'($urandom_range(1, 255)); wdata_valid = 1'b1;
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0; wdata_valid = 1'b0;
    #1;
    check("rst_rel_rdy", cmd_ready, 1);
    check("rst_rel_busy", busy, 0);
    read_burst(10'h100, 3, -1, 0);

    // Back-to-back single-beat writes
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wdata_valid = 1'b0;
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 10'h200 + 10'(k * 7); cmd_len = 4'd0;
      #1;
      check("s_wr_rdy", cmd_ready, 1);
      check("s_wr_idle", busy, 0);
      @(negedge clk);
      cmd_valid = 1'b0;
      d = 8'($urandom);
      wdata = d; wdata_valid = 1'b1;
      ref_mem[10'h200 + 10'(k * 7)] = d;
      #1;
      check("s_wr_wr", ram_wr, 1);
      check("s_wr_addr", ram_addr, 10'h200 + 10'(k * 7));
    end
    // Back-to-back single-beat reads; each beat is still pending at next accept
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wdata_valid = 1'b0;
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 10'h200 + 10'(k * 7); cmd_len = 4'd0;
      #1;
      check("s_rd_rdy", cmd_ready, 1);
      if (k > 0) begin
        check("s_rd_pend_v", rdata_valid, 1);
        check("s_rd_pend_d", rdata, ref_mem[10'h200 + 10'((k - 1) * 7)]);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      check("s_rd_busy", busy, 1);
      check("s_rd_addr", ram_addr, 10'h200 + 10'(k * 7));
    end
    @(negedge clk);
    #1;
    check("s_rd_last_v", rdata_valid, 1);
    check("s_rd_last_d", rdata, ref_mem[10'h200 + 10'd14]);
    check("s_rd_last_rdy", cmd_ready, 1);
    @(negedge clk);
    #1 check("s_rd_drained", rdata_valid, 0);

    // Randomized bursts
    for (int n = 0; n < 6; n++) begin
      a = 10'($urandom);
      len = $urandom_range(0, 15);
      write_burst(a, len, -1, $urandom_range(0, len), $urandom_range(0, 2));
      read_burst(a, len, $urandom_range(1, len + 1), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Burst sequencer that sits directly upstream of the single-port RAM (async read, sync write). It accepts burst commands from a host over a valid/ready handshake and drives the RAM `addr`/`data_in`/`wr`/`cs` pins with auto-incrementing addresses. It streams write data in and streams registered read data out, so the host never touches RAM timing directly.

## Interface
- `word_size`, default 8: data width; matches the RAM.
- `addr_size`, default 10: address width; the RAM depth is 2^addr_size (1024).
- `len_size`, default 4: burst length field width; a burst is `cmd_len`+1 beats (1..16).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_wr` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in addr_size: burst start address.
- `cmd_len` in len_size: beats minus 1.
- `wdata` in word_size: write beat data.
- `wdata_valid` in 1: write beat present.
- `wdata_ready` out 1: write beat accepted this cycle when `wdata_valid` is also high.
- `rdata` out word_size: read beat data (registered).
- `rdata_valid` out 1: `rdata` holds an unconsumed beat.
- `rdata_ready` in 1: consumer takes `rdata` this cycle.
- `busy` out 1: a burst is in progress (state is not IDLE).
- `ram_addr` out addr_size: drives RAM `addr`.
- `ram_data_in` out word_size: drives RAM `data_in`.
- `ram_wr` out 1: drives RAM `wr`.
- `ram_cs` out 1: drives RAM `cs`.
- `ram_data_out` in word_size: from RAM `data_out` (combinational read).

## Operation
- The FSM has three states: IDLE, WRITE and READ. Internal registers: `addr_q` (addr_size), `cnt_q` (len_size, beats remaining minus 1), `rdata`, `rdata_valid`.
- IDLE:
  - `cmd_ready` = 1 (forced 0 while `rst` high).
  - On `cmd_valid && cmd_ready`: load `addr_q` ← `cmd_addr` and `cnt_q` ← `cmd_len`, then go to WRITE if `cmd_wr`, else READ.
- WRITE:
  - `wdata_ready` = 1.
  - `ram_cs` = `ram_wr` = `wdata_valid`, combinationally; `ram_addr` = `addr_q`; `ram_data_in` = `wdata`.
  - On an accepted beat: the RAM write happens at that edge; `addr_q`++; if `cnt_q`==0 go to IDLE, else `cnt_q`--.
  - With `wdata_valid` low, the controller stalls, does not write and holds the address.
- READ:
  - `ram_cs` = 1, `ram_wr` = 0, `ram_addr` = `addr_q`.
  - Capture condition: `!rdata_valid || rdata_ready`.
  - When the capture condition holds: `rdata` ← `ram_data_out`, `rdata_valid` ← 1, `addr_q`++; if `cnt_q`==0 go to IDLE, else `cnt_q`--.
  - When it does not hold, the controller stalls and holds the address.
- Output slot, outside READ: `rdata_ready && rdata_valid` clears `rdata_valid`. A new command may be accepted while `rdata_valid` is still pending.
- Address arithmetic: `addr_q`++ wraps modulo 2^addr_size; address 1023 + 1 = 0. A burst may cross the wrap.
- Signals not driven by an active state:
  - `ram_cs` = `ram_wr` = 0 and `wdata_ready` = 0.
  - `ram_addr` = `addr_q`.
  - `ram_data_in` = `wdata` (passed through at all times).

## Timing
- Reset values: state IDLE, `addr_q` 0, `cnt_q` 0, `rdata` 0, `rdata_valid` 0, `busy` 0, `cmd_ready` 0 (while `rst` is high), `wdata_ready` 0, `ram_wr` 0, `ram_cs` 0, `ram_addr` 0.
- Command acceptance: the command is taken at edge E. The burst state is active from the cycle after E; there is no bubble cycle.
- Write beat latency: a write beat presented in a WRITE cycle is written to the RAM at that same edge. An N-beat write burst with `wdata_valid` held high occupies exactly N cycles after the accept cycle.
- Read latency: the first `rdata_valid` rises at the edge ending the first READ cycle, i.e. one cycle after the accept edge. With `rdata_ready` held high, throughput is 1 beat per cycle and an N-beat read occupies N cycles.
- `busy` is high exactly in WRITE and READ. `cmd_ready` and `busy` are mutually exclusive outside reset.
- Back-to-back commands: the earliest next accept is the cycle the FSM returns to IDLE. There is no overlap between bursts.
- Reset mid-burst: all outputs go to their reset values immediately (asynchronously) and the burst is aborted. RAM contents already written are retained, and no partial beat is written after `rst` rises.
- Simultaneous READ capture and consume: old `rdata` is consumed and new `rdata` loaded at the same edge; `rdata_valid` stays 1.

## Test plan
- Reset, then a write of `cmd_addr`=0x010, `cmd_len`=3 with `wdata` 0xA0..0xA3 streamed continuously → `ram_wr`=1 for exactly 4 cycles at `ram_addr` 0x010..0x013. A following read of 0x010 with len 3 and `rdata_ready`=1 → `rdata` 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles, the first one cycle after accept.
- Wrap-around: write at `cmd_addr`=0x3FE, `cmd_len`=3 → addresses 0x3FE, 0x3FF, 0x000, 0x001. Read-back of the same burst returns the identical data.
- Write stall: drop `wdata_valid` for 2 cycles mid-burst → `ram_wr`=0 during the gap, the address holds, the burst completes with the correct data and `busy` stretches by 2 cycles.
- Read backpressure: hold `rdata_ready`=0 for 3 cycles during a 4-beat read → `rdata` is stable, the address holds and no beat is lost or duplicated (read-back order is exact).
- Assert `rst` during beat 2 of a 4-beat write, release and read back → only beats 0..1 are written. All outputs are at reset values while `rst` is high, and `cmd_ready`=1 after release.
- Single-beat commands (`cmd_len`=0) issued back-to-back → each completes in 1 cycle after accept, and `cmd_ready` returns to 1 the next cycle.
